// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller types and timing constants.
// Holds the refresh-quiesce state encoding and the precharge recovery time.
// Pure declarations; no logic.
package ddr3_pkg;

  // Refresh quiesce FSM states; unused encodings fall back to RUN in the FSM.
  typedef enum logic [2:0] {
    QS_RUN       = 3'd0,
    QS_DRAIN     = 3'd1,
    QS_PRECHARGE = 3'd2,
    QS_WAIT_TRP  = 3'd3,
    QS_IDLE_HOLD = 3'd4,
    QS_REFRESH   = 3'd5
  } quiesce_state_t;

  // Row precharge time in core clock cycles.
  localparam logic [4:0] tRP_CYCLES = 5'd6;

endpackage

// File: rtl/refresh_quiesce.sv
// Quiesces all banks before a DDR3 REFRESH: drain, PRECHARGE-ALL, wait tRP, hold idle, count refreshes.
// Latency: all_IDLE 2 cycles after refresh_imminent when banks are closed; tRP_CYCLES+1 after the PRECHARGE-ALL handshake otherwise.
// Backpressure: pre_all_valid stays asserted until pre_all_ready; outputs are decoded from the state register.
module refresh_quiesce
  import ddr3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh_imminent,
  input  logic        ddr_refresh,
  input  logic [7:0]  bank_open,
  input  logic [7:0]  bank_busy,
  input  logic        pre_all_ready,
  output logic        pre_all_valid,
  output logic        block_new_req,
  output logic        all_IDLE,
  output logic [15:0] refresh_count
);

  quiesce_state_t r_state;
  logic [4:0]     r_trp;
  logic [15:0]    r_refresh_count;

  logic w_any_open;
  logic w_any_busy;
  logic w_trp_zero;

  assign w_any_open = |bank_open;
  assign w_any_busy = |bank_busy;
  assign w_trp_zero = (r_trp == 5'd0);

  // Moore outputs decoded straight from the state register.
  assign pre_all_valid = (r_state == QS_PRECHARGE);
  assign block_new_req = (r_state != QS_RUN);
  assign all_IDLE      = (r_state == QS_IDLE_HOLD);
  assign refresh_count = r_refresh_count;

  // State transitions and the inline tRP down-counter. A refresh seen outside
  // IDLE_HOLD/REFRESH jumps straight to REFRESH: once the DRAM is refreshing,
  // any drain or precharge in flight is moot, so that path outranks everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= QS_RUN;
      r_trp   <= 5'd0;
    end else begin
      case (r_state)
        QS_RUN: begin
          if (ddr_refresh)           r_state <= QS_REFRESH;
          else if (refresh_imminent) r_state <= QS_DRAIN;
        end
        QS_DRAIN: begin
          if (ddr_refresh)           r_state <= QS_REFRESH;
          else if (!w_any_busy)      r_state <= w_any_open ? QS_PRECHARGE : QS_IDLE_HOLD;
          else if (!refresh_imminent) r_state <= QS_RUN;
        end
        QS_PRECHARGE: begin
          if (ddr_refresh) begin
            r_state <= QS_REFRESH;
          end else if (pre_all_ready) begin
            r_state <= QS_WAIT_TRP;
            r_trp   <= tRP_CYCLES - 5'd1;
          end
        end
        QS_WAIT_TRP: begin
          if (!w_trp_zero) r_trp <= r_trp - 5'd1;
          if (ddr_refresh)     r_state <= QS_REFRESH;
          else if (w_trp_zero) r_state <= w_any_open ? QS_PRECHARGE : QS_IDLE_HOLD;
        end
        QS_IDLE_HOLD: begin
          if (ddr_refresh)                    r_state <= QS_REFRESH;
          else if (w_any_open || w_any_busy)  r_state <= QS_DRAIN;
          else if (!refresh_imminent)         r_state <= QS_RUN;
        end
        QS_REFRESH: begin
          if (!ddr_refresh) r_state <= QS_RUN;
        end
        default: r_state <= QS_RUN;
      endcase
    end
  end

  // Completed-refresh counter: bumps on the cycle REFRESH ends; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh_count <= 16'd0;
    end else if ((r_state == QS_REFRESH) && !ddr_refresh) begin
      r_refresh_count <= r_refresh_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_refresh_quiesce.sv
// Bench for refresh_quiesce: vector table, directed corner sequences, random run against a rule model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// All waits are fixed cycle counts so the run always terminates.
module tb_refresh_quiesce;
  import ddr3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        refresh_imminent;
  logic        ddr_refresh;
  logic [7:0]  bank_open;
  logic [7:0]  bank_busy;
  logic        pre_all_ready;
  logic        pre_all_valid;
  logic        block_new_req;
  logic        all_IDLE;
  logic [15:0] refresh_count;

  int n_checks = 0;
  int n_errors = 0;

  refresh_quiesce dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .refresh_imminent (refresh_imminent),
    .ddr_refresh      (ddr_refresh),
    .bank_open        (bank_open),
    .bank_busy        (bank_busy),
    .pre_all_ready    (pre_all_ready),
    .pre_all_valid    (pre_all_valid),
    .block_new_req    (block_new_req),
    .all_IDLE         (all_IDLE),
    .refresh_count    (refresh_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        imm;
    logic        rfr;
    logic [7:0]  open;
    logic [7:0]  busy;
    logic        ready;
    logic [2:0]  exp_vbi;   // {pre_all_valid, block_new_req, all_IDLE}
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  // Model phases, named after the behaviour rather than any encoding.
  localparam int M_RUN = 0, M_DRAIN = 1, M_PRE = 2, M_WAIT = 3, M_IDLE = 4, M_REF = 5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    refresh_imminent = 1'b0;
    ddr_refresh      = 1'b0;
    bank_open        = 8'h00;
    bank_busy        = 8'h00;
    pre_all_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int m_state, m_trp, m_cnt;
    int v_cnt, hs_cnt;
    logic bad_valid, bad_idle, bad_ref;

    rst_n = 1'b0;
    idle_inputs();
    tick();
    chk("reset_valid", 32'(pre_all_valid), 32'd0);
    chk("reset_block", 32'(block_new_req), 32'd0);
    chk("reset_idle",  32'(all_IDLE),      32'd0);
    chk("reset_count", 32'(refresh_count), 32'd0);

    // ---------------- vector table ----------------
    //           rst  imm  rfr  open   busy   rdy  {v,b,i} cnt
    vecs[0]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,3'b000,16'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,8'h00,8'h00,1'b0,3'b010,16'd0};
    vecs[2]  = '{1'b1,1'b1,1'b0,8'h00,8'h00,1'b0,3'b011,16'd0};
    vecs[3]  = '{1'b1,1'b1,1'b0,8'h00,8'h00,1'b0,3'b011,16'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,3'b000,16'd0};
    vecs[5]  = '{1'b1,1'b1,1'b0,8'h00,8'h01,1'b0,3'b010,16'd0};
    vecs[6]  = '{1'b1,1'b0,1'b0,8'h00,8'h01,1'b0,3'b000,16'd0};
    vecs[7]  = '{1'b1,1'b1,1'b0,8'h00,8'h01,1'b0,3'b010,16'd0};
    vecs[8]  = '{1'b1,1'b1,1'b0,8'h00,8'h00,1'b0,3'b011,16'd0};
    vecs[9]  = '{1'b1,1'b1,1'b0,8'h02,8'h00,1'b0,3'b010,16'd0};
    vecs[10] = '{1'b1,1'b1,1'b0,8'h02,8'h00,1'b0,3'b110,16'd0};
    vecs[11] = '{1'b1,1'b0,1'b0,8'h02,8'h00,1'b0,3'b110,16'd0};
    vecs[12] = '{1'b1,1'b0,1'b0,8'h02,8'h00,1'b1,3'b010,16'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,3'b000,16'd0};
    vecs[14] = '{1'b1,1'b0,1'b1,8'h00,8'h00,1'b0,3'b010,16'd0};
    vecs[15] = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,3'b000,16'd1};

    for (int i = 0; i < 16; i++) begin
      rst_n            = vecs[i].rst_n;
      refresh_imminent = vecs[i].imm;
      ddr_refresh      = vecs[i].rfr;
      bank_open        = vecs[i].open;
      bank_busy        = vecs[i].busy;
      pre_all_ready    = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_outs", i), 32'({pre_all_valid, block_new_req, all_IDLE}), 32'(vecs[i].exp_vbi));
      chk($sformatf("vec%0d_count", i), 32'(refresh_count), 32'(vecs[i].exp_cnt));
    end

    // ---------------- open banks, ready tied high ----------------
    do_reset();
    refresh_imminent = 1'b1;
    bank_open        = 8'h05;
    pre_all_ready    = 1'b1;
    tick();                                  // DRAIN
    chk("open_drain_block", 32'(block_new_req), 32'd1);
    tick();                                  // PRECHARGE, handshake this cycle
    chk("open_pre_valid", 32'(pre_all_valid), 32'd1);
    v_cnt = 1;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) bank_open = 8'h00;
      tick();
      if (pre_all_valid) v_cnt++;
      if (c == 6) chk("open_idle_early", 32'(all_IDLE), 32'd0);
      if (c == 7) chk("open_idle_hs_plus7", 32'(all_IDLE), 32'd1);
    end
    chk("open_single_pulse", 32'(v_cnt), 32'd1);

    // ---------------- PRECHARGE-ALL backpressure ----------------
    do_reset();
    refresh_imminent = 1'b1;
    bank_open        = 8'h05;
    pre_all_ready    = 1'b0;
    tick();                                  // DRAIN
    tick();                                  // PRECHARGE
    v_cnt  = 0;
    hs_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      pre_all_ready = (k >= 4);
      if (pre_all_valid) begin
        v_cnt++;
        if (pre_all_ready) hs_cnt++;
      end
      tick();
    end
    chk("bp_valid_cycles", 32'(v_cnt), 32'd5);
    chk("bp_handshakes",   32'(hs_cnt), 32'd1);

    // ---------------- busy drain ----------------
    do_reset();
    refresh_imminent = 1'b1;
    bank_busy        = 8'h80;
    bad_valid = 1'b0;
    bad_idle  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pre_all_valid) bad_valid = 1'b1;
      if (all_IDLE)      bad_idle  = 1'b1;
    end
    chk("busy_no_valid", 32'(bad_valid), 32'd0);
    chk("busy_no_idle",  32'(bad_idle),  32'd0);
    chk("busy_block",    32'(block_new_req), 32'd1);
    bank_busy = 8'h00;
    tick();
    chk("busy_clear_idle", 32'(all_IDLE), 32'd1);

    // ---------------- full refresh with count wrap ----------------
    force dut.r_refresh_count = 16'hFFFF;
    tick();
    release dut.r_refresh_count;
    ddr_refresh = 1'b1;
    tick();
    chk("ref_idle_drop", 32'(all_IDLE), 32'd0);
    chk("ref_state", 32'(dut.r_state), 32'(QS_REFRESH));
    bad_ref = 1'b0;
    for (int k = 1; k < 40; k++) begin
      tick();
      if (all_IDLE || !block_new_req || pre_all_valid) bad_ref = 1'b1;
    end
    chk("ref_hold_outputs", 32'(bad_ref), 32'd0);
    chk("ref_count_before", 32'(refresh_count), 32'hFFFF);
    ddr_refresh      = 1'b0;
    refresh_imminent = 1'b0;
    tick();
    chk("ref_run_state", 32'(dut.r_state), 32'(QS_RUN));
    chk("ref_count_wrap", 32'(refresh_count), 32'h0000);

    // ---------------- reset while waiting on tRP ----------------
    do_reset();
    ddr_refresh = 1'b1;
    tick();
    ddr_refresh = 1'b0;
    tick();
    chk("rst_pre_count", 32'(refresh_count), 32'd1);
    refresh_imminent = 1'b1;
    bank_open        = 8'h05;
    pre_all_ready    = 1'b1;
    tick();                                  // DRAIN
    tick();                                  // PRECHARGE
    tick();                                  // WAIT_TRP
    tick();
    chk("rst_in_wait_trp", 32'(dut.r_state), 32'(QS_WAIT_TRP));
    rst_n = 1'b0;
    tick();
    chk("rst_outs",  32'({pre_all_valid, block_new_req, all_IDLE}), 32'd0);
    chk("rst_count", 32'(refresh_count), 32'd0);
    chk("rst_trp",   32'(dut.r_trp), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();
    chk("rst_after_outs", 32'({pre_all_valid, block_new_req, all_IDLE}), 32'd0);

    // ---------------- randomized run against a rule model ----------------
    do_reset();
    m_state = M_RUN;
    m_trp   = 0;
    m_cnt   = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      refresh_imminent = ($urandom_range(0, 9) != 0);
      if (ddr_refresh) ddr_refresh = ($urandom_range(0, 3) != 0);
      else             ddr_refresh = ($urandom_range(0, 29) == 0);
      bank_open        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bank_busy        = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      pre_all_ready    = 1'($urandom_range(0, 1));
      tick();

      if (!rst_n) begin
        m_state = M_RUN;
        m_trp   = 0;
        m_cnt   = 0;
      end else if (m_state == M_REF) begin
        if (!ddr_refresh) begin
          m_state = M_RUN;
          m_cnt   = (m_cnt + 1) % 65536;
        end
      end else if (ddr_refresh) begin
        m_state = M_REF;
      end else begin
        case (m_state)
          M_RUN:   if (refresh_imminent) m_state = M_DRAIN;
          M_DRAIN: begin
            if (bank_busy == 0)         m_state = (bank_open != 0) ? M_PRE : M_IDLE;
            else if (!refresh_imminent) m_state = M_RUN;
          end
          M_PRE: if (pre_all_ready) begin
            m_state = M_WAIT;
            m_trp   = int'(tRP_CYCLES) - 1;
          end
          M_WAIT: begin
            if (m_trp == 0) m_state = (bank_open != 0) ? M_PRE : M_IDLE;
            else            m_trp   = m_trp - 1;
          end
          M_IDLE: begin
            if (bank_open != 0 || bank_busy != 0) m_state = M_DRAIN;
            else if (!refresh_imminent)           m_state = M_RUN;
          end
          default: m_state = M_RUN;
        endcase
      end

      chk($sformatf("rnd%0d_valid", c), 32'(pre_all_valid), 32'(m_state == M_PRE));
      chk($sformatf("rnd%0d_block", c), 32'(block_new_req), 32'(m_state != M_RUN));
      chk($sformatf("rnd%0d_idle",  c), 32'(all_IDLE),      32'(m_state == M_IDLE));
      chk($sformatf("rnd%0d_count", c), 32'(refresh_count), 32'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
